// File: rtl/sram_pkg.sv
// Shared types and constants for the sram_wrapper result-beat serializer.
package sram_pkg;

   localparam int DATA_W = 512;
   localparam int OUT_W  = 32;
   localparam int WORDS  = DATA_W / OUT_W;
   localparam int IDX_W  = $clog2(WORDS);

   typedef logic [DATA_W-1:0] beat_t;
   typedef logic [OUT_W-1:0]  word_t;
   typedef logic [IDX_W-1:0]  idx_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Word i of a beat, word 0 being the least-significant OUT_W bits.
   function automatic word_t beat_word(beat_t b, idx_t i);
      word_t [WORDS-1:0] w;
      w = b;
      return w[i];
   endfunction

endpackage

// File: rtl/sram_out_serializer_if.sv
// Beat input and word output stream of the serializer.
//
// Handshakes: sram_out is qualified by valid_out alone and is sampled on every
// rising edge; it has no ready and cannot be stalled. The word stream moves a
// word on each rising edge where m_valid && m_ready; while m_valid is high and
// m_ready low, m_data/m_last hold their values and m_valid stays high.
interface sram_out_serializer_if;
   import sram_pkg::*;

   beat_t sram_out;
   logic  valid_out;
   word_t m_data;
   logic  m_valid;
   logic  m_ready;
   logic  m_last;

   // master: the environment around the block (beat producer + word sink)
   modport master (
      output sram_out, valid_out, m_ready,
      input  m_data, m_valid, m_last
   );

   // slave: the serializer itself
   modport slave (
      input  sram_out, valid_out, m_ready,
      output m_data, m_valid, m_last
   );
endinterface

// File: rtl/sram_beat_fifo.sv
// DEPTH-entry beat FIFO; a push is accepted while full when the head is
// popped on the same edge. Exposes the entry behind the head so the
// serializer can preload the next beat's first word without a gap cycle.
module sram_beat_fifo
   import sram_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  beat_t                  din,
   output logic                   full,
   output logic                   empty,
   output beat_t                  head,
   output beat_t                  next_head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   beat_t          mem [DEPTH];
   logic [AW:0]    wptr;
   logic [AW:0]    rptr;
   logic [AW-1:0]  rnext_addr;
   logic           do_pop;
   logic           do_push;

   assign empty      = (wptr == rptr);
   assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count      = wptr - rptr;
   assign do_pop     = pop && !empty;
   assign do_push    = push && (!full || do_pop);
   assign rnext_addr = rptr[AW-1:0] + AW'(1);
   assign head       = mem[rptr[AW-1:0]];
   assign next_head  = mem[rnext_addr];

   // Read/write pointers; extra MSB distinguishes full from empty.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage; contents need no reset since empty gates every read.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sram_out_serializer.sv
// Buffers 512-bit sram_wrapper result beats and re-emits each as 32-bit words
// (least-significant first) on a valid/ready stream, counting sent and
// dropped beats.
module sram_out_serializer
   import sram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                CLK,
   input  logic                RST,
   sram_out_serializer_if.slave bus,
   output logic                overflow,
   output logic [CNT_W-1:0]    beat_cnt,
   output logic [CNT_W-1:0]    drop_cnt,
   output state_e              dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [1:0]    rst_sync;
   logic          rst_n;

   state_e        state_q, state_nx;
   idx_t          idx_q, idx_nx;
   word_t         m_data_q, data_nx;
   logic          m_valid_q, valid_nx;
   logic          m_last_q, last_nx;
   beat_t         src_beat;

   logic          full, empty;
   beat_t         head, next_head;
   logic [AW:0]   count;
   logic          hs, word_last, pop_en, push_en, drop, more_after;

   // Reset asserts immediately and releases on the second CLK edge after RST rises.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign hs         = m_valid_q && bus.m_ready;
   assign word_last  = (idx_q == idx_t'(WORDS-1));
   assign pop_en     = hs && word_last && (state_q == SEND);
   assign push_en    = bus.valid_out && (!full || pop_en);
   assign drop       = bus.valid_out && full && !pop_en;
   // After a pop, another beat remains if one was queued or arrives this edge.
   assign more_after = (count > CW'(1)) || push_en;

   sram_beat_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .push      (push_en),
      .pop       (pop_en),
      .din       (bus.sram_out),
      .full      (full),
      .empty     (empty),
      .head      (head),
      .next_head (next_head),
      .count     (count)
   );

   // FSM state and word index register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_nx;
         idx_q   <= idx_nx;
      end
   end

   // Next state: advance the word index per handshake, pop on the last word.
   always_comb begin
      state_nx = state_q;
      idx_nx   = idx_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_nx = SEND;
               idx_nx   = '0;
            end
         end
         SEND: begin
            if (hs) begin
               if (word_last) begin
                  idx_nx   = '0;
                  state_nx = more_after ? SEND : IDLE;
               end else begin
                  idx_nx = idx_q + idx_t'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = '0;
         end
      endcase
   end

   // Output decode: the word presented after the edge, from the beat that will be head then.
   always_comb begin
      src_beat = head;
      if (pop_en) src_beat = (count > CW'(1)) ? next_head : bus.sram_out;
      valid_nx = (state_nx == SEND);
      data_nx  = valid_nx ? beat_word(src_beat, idx_nx) : '0;
      last_nx  = valid_nx && (idx_nx == idx_t'(WORDS-1));
   end

   // Registered stream outputs; no combinational path from m_ready.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         m_data_q  <= data_nx;
         m_valid_q <= valid_nx;
         m_last_q  <= last_nx;
      end
   end

   // Sent-beat counter wraps; drop counter saturates; overflow is sticky.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop_en) beat_cnt <= beat_cnt + CNT_W'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.m_data  = m_data_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_last  = m_last_q;
   assign dbg_state   = state_q;

endmodule

// File: doc/sram_out_serializer.md
Name: sram_out_serializer

Overview:
- Receive-side consumer of the sram_wrapper output interface.
- Accepts 512-bit result beats on the wrapper's valid_out/sram_out pair. That pair has no backpressure, so this block buffers the beats in a small FIFO.
- Re-emits each beat as 32-bit words over a valid/ready stream to the narrower downstream bus (host readback / DMA).
- Flags and counts beats lost to overflow.

Parameters:
- DATA_W, 512, width of one sram_wrapper result beat.
- OUT_W, 32, downstream word width; DATA_W must be an integer multiple of OUT_W.
- WORDS, DATA_W/OUT_W (16), words per beat; derived, not overridden.
- DEPTH, 4, FIFO depth in beats; power of two, at least 2.
- CNT_W, 16, width of the beat and drop counters.

Ports:
- CLK  input  1  single clock, rising-edge.
- RST  input  1  asynchronous, active-low reset (asserted at 0).
- sram_out  input  DATA_W  result beat from sram_wrapper.
- valid_out  input  1  beat qualifier; sampled every rising edge, no ready back.
- m_data  output  OUT_W  current output word.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts when m_valid && m_ready at a rising edge.
- m_last  output  1  high with the final word (index WORDS-1) of a beat.
- overflow  output  1  sticky: at least one beat was dropped since reset.
- beat_cnt  output  CNT_W  beats fully sent downstream; wraps modulo 2^CNT_W.
- drop_cnt  output  CNT_W  beats dropped; saturates at all-ones.

Behaviour:
- Reset (RST=0, async): FIFO empty, word_idx=0, FSM=IDLE, m_valid=0, m_last=0, m_data=0, overflow=0, beat_cnt=0, drop_cnt=0. Deassertion is synchronised internally; first active edge is the second CLK edge after RST rises.
- FIFO: DEPTH x DATA_W entries. Pointers are log2(DEPTH)+1 bits wide; full/empty are derived from the MSB comparison.
- Push when valid_out=1 and (not full, or a pop occurs in the same cycle).
- Drop when valid_out=1 and full with no pop that cycle. On a drop: overflow<=1 and drop_cnt increments (saturating). FIFO contents are untouched.
- FSM:
  - IDLE: m_valid=0. If the FIFO is non-empty, go to SEND with word_idx=0.
  - SEND: m_valid=1; m_data = head[OUT_W*word_idx +: OUT_W], least-significant word first; m_last = (word_idx==WORDS-1).
  - On a handshake with word_idx<WORDS-1: word_idx++.
  - On a handshake with word_idx==WORDS-1: pop the head, beat_cnt++, word_idx<=0. Stay in SEND if the FIFO still holds another beat after this edge (counting a same-cycle push); otherwise go to IDLE.
- m_data, m_valid and m_last are registered, with zero combinational path from m_ready. They stay stable while m_valid && !m_ready.
- Latency: with an empty FIFO, a beat sampled at edge E0 gives m_valid=1 after edge E1. Back-to-back beats in the FIFO stream with no idle cycle between m_last and the next word 0.
- Throughput: 1 beat per WORDS cycles at m_ready=1. Input bursts longer than DEPTH plus the in-flight drain overflow by design.
- Reset mid-beat: the partially sent beat is discarded and no m_last is issued.
- Counter wrap: beat_cnt rolls 0xFFFF->0 silently; drop_cnt holds at 0xFFFF.

Decomposition:
- Shared package sram_pkg: DATA_W=512, OUT_W=32, WORDS, a beat_t typedef (logic [511:0]), a word_t typedef (logic [31:0]), and the FSM state enum {IDLE, SEND}.
- One sub-module, sram_beat_fifo (DEPTH x DATA_W, push/pop/full/empty, same-cycle push-on-pop when full). The serializer FSM and counters stay in the top module.

Test Plan:
- Single beat, data word k = 32'h1000_0000+k for k=0..15, m_ready=1 -> m_valid rises one cycle after push; 16 consecutive words 0x10000000..0x1000000F; m_last only on 0x1000000F; beat_cnt=1; overflow=0.
- Same beat, m_ready toggling 1,0,1,0 -> each word held stable across its stall cycles; exactly 16 handshakes; word order unchanged.
- 5 back-to-back beats (pattern b in every word, b=0..4), m_ready=0 -> 4 stored, beat 4 dropped; overflow=1, drop_cnt=1. Then m_ready=1 -> 64 words for beats 0..3, beat_cnt=4.
- FIFO full; a push lands on the same edge as the final-word handshake of the head -> push accepted, drop_cnt unchanged, next beat starts with no gap cycle.
- RST pulsed low during word 7 of a beat -> m_valid=0 immediately (async); all counters 0; overflow=0. A fresh beat afterwards streams from word 0.
- 64 beats at 1/cycle (test-pattern style), m_ready=1 -> overflow=1; beat_cnt + drop_cnt = 64; delivered beats match the input beats in order.
